// File: rtl/enc_sched_pkg.sv
// Shared types and defaults for the encoder sample scheduler.
// Include this file first; encoder_sample_scheduler.sv and rr_arbiter.sv import it.
package enc_sched_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } sched_state_t;

    localparam int WINDOW_CYCLES_DEF = 100000;
    localparam int CNT_W_DEF         = 16;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set pending bit at or above ptr, wrapping.
// The caller owns and advances ptr.
module rr_arbiter
    import enc_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CH_W = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   grant_idx,
    output logic              any
);

    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_CH) begin
                j = j - NUM_CH;
            end
            if (!any && pending[j]) begin
                any       = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = CH_W'(j);
            end
        end
    end

endmodule

// File: rtl/encoder_sample_scheduler.sv
// Sample-window strobe plus per-channel result capture, round-robin onto one valid/ready stream.
// Optional ENC_SCHED_SEQ_TAG_EN adds an 8-bit o_Seq tag that advances on every accepted transfer.
module encoder_sample_scheduler
    import enc_sched_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    input  logic                      i_Enable,
    output logic                      o_Sample_Strobe,
    input  logic [NUM_CH-1:0]         i_Data_Ready,
    input  logic [NUM_CH*CNT_W-1:0]   i_Pulse_Count,
    output logic                      o_Valid,
    input  logic                      i_Ready,
    output logic [ch_width(NUM_CH)-1:0] o_Channel,
    output logic [CNT_W-1:0]          o_Count,
`ifdef ENC_SCHED_SEQ_TAG_EN
    output logic [7:0]                o_Seq,
`endif
    output logic [NUM_CH-1:0]         o_Overrun,
    input  logic                      i_Overrun_Clear
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int TMR_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    logic [TMR_W-1:0]  timer_q;
    logic              strobe_q;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] pending_d;
    logic [CNT_W-1:0]  hold_q [NUM_CH];
    logic [CH_W-1:0]   ptr_q;
    logic [CH_W-1:0]   chan_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [NUM_CH-1:0] ovr_q;
    logic [NUM_CH-1:0] ovr_set;
    logic [NUM_CH-1:0] grant_oh;
    logic [NUM_CH-1:0] grant_taken;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_any;
    logic              load;
    logic              accept;
    sched_state_t      state_q;
    sched_state_t      state_d;

    always_ff @(posedge i_Clk) begin
        if (i_Reset || !i_Enable) begin
            timer_q  <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= (timer_q == TMR_LAST);
            timer_q  <= (timer_q == TMR_LAST) ? '0 : timer_q + 1'b1;
        end
    end

    rr_arbiter #(
        .NUM_CH(NUM_CH)
    ) u_arb (
        .pending  (pending_q),
        .ptr      (ptr_q),
        .grant    (grant_oh),
        .grant_idx(grant_idx),
        .any      (grant_any)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    load    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (i_Ready) begin
                    accept = 1'b1;
                    if (grant_any) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A channel being granted this cycle hands over its old value, so a fresh capture is not an overrun.
    always_comb begin
        grant_taken = load ? grant_oh : '0;
        pending_d   = (pending_q & ~grant_taken) | i_Data_Ready;
        ovr_set     = i_Data_Ready & pending_q & ~grant_taken;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ptr_q     <= '0;
            chan_q    <= '0;
            cnt_q     <= '0;
            ovr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ovr_q     <= (i_Overrun_Clear ? '0 : ovr_q) | ovr_set;
            if (load) begin
                chan_q <= grant_idx;
                cnt_q  <= hold_q[grant_idx];
                ptr_q  <= (grant_idx == CH_LAST) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (i_Reset) begin
                hold_q[k] <= '0;
            end else if (i_Data_Ready[k]) begin
                hold_q[k] <= i_Pulse_Count[k*CNT_W +: CNT_W];
            end
        end
    end

`ifdef ENC_SCHED_SEQ_TAG_EN
    logic [7:0] seq_q;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            seq_q <= 8'd0;
        end else if (accept) begin
            seq_q <= seq_q + 8'd1;
        end
    end

    assign o_Seq = seq_q;
`endif

    assign o_Sample_Strobe = strobe_q;
    assign o_Valid         = (state_q == PRESENT);
    assign o_Channel       = chan_q;
    assign o_Count         = cnt_q;
    assign o_Overrun       = ovr_q;

endmodule

// File: tb/tb_encoder_sample_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model.
`timescale 1ns/1ps
module tb_encoder_sample_scheduler;

    localparam int N  = 4;
    localparam int CW = 16;
    localparam int WC = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          strobe;
    logic [N-1:0]  dr;
    logic [N*CW-1:0] pc;
    logic          valid;
    logic          rdy;
    logic [1:0]    chan;
    logic [CW-1:0] cnt;
    logic [N-1:0]  ovr;
    logic          oclr;
`ifdef ENC_SCHED_SEQ_TAG_EN
    logic [7:0]    seq;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state, kept as plain integers per the behavioural rules.
    int m_pend[N];
    int m_hold[N];
    int m_ovr[N];
    int m_ptr, m_valid, m_ch, m_cnt, m_timer, m_strobe, m_seq;

    always #5 clk = ~clk;

    encoder_sample_scheduler #(
        .NUM_CH(N),
        .WINDOW_CYCLES(WC),
        .CNT_W(CW)
    ) dut (
        .i_Clk          (clk),
        .i_Reset        (rst),
        .i_Enable       (en),
        .o_Sample_Strobe(strobe),
        .i_Data_Ready   (dr),
        .i_Pulse_Count  (pc),
        .o_Valid        (valid),
        .i_Ready        (rdy),
        .o_Channel      (chan),
        .o_Count        (cnt),
`ifdef ENC_SCHED_SEQ_TAG_EN
        .o_Seq          (seq),
`endif
        .o_Overrun      (ovr),
        .i_Overrun_Clear(oclr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_cnt(input int ch, input int v);
        pc[ch*CW +: CW] = CW'(v);
    endtask

    function automatic int ovr_vec();
        int v = 0;
        for (int k = 0; k < N; k++) v |= (m_ovr[k] << k);
        return v;
    endfunction

    task automatic model_edge();
        int grant;
        int set_k[N];
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                m_pend[k] = 0; m_hold[k] = 0; m_ovr[k] = 0;
            end
            m_ptr = 0; m_valid = 0; m_ch = 0; m_cnt = 0;
            m_timer = 0; m_strobe = 0; m_seq = 0;
            return;
        end
        if (!en) begin
            m_timer = 0; m_strobe = 0;
        end else begin
            m_strobe = (m_timer == WC - 1) ? 1 : 0;
            m_timer  = (m_timer + 1) % WC;
        end
        grant = -1;
        if (!m_valid || rdy) begin
            for (int i = 0; i < N; i++) begin
                if (grant < 0 && m_pend[(m_ptr + i) % N] != 0) grant = (m_ptr + i) % N;
            end
        end
        for (int k = 0; k < N; k++) set_k[k] = (dr[k] && m_pend[k] != 0 && grant != k) ? 1 : 0;
        if (m_valid && rdy) m_seq = (m_seq + 1) % 256;
        if (grant >= 0) begin
            m_valid = 1; m_ch = grant; m_cnt = m_hold[grant];
            m_pend[grant] = 0; m_ptr = (grant + 1) % N;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        for (int k = 0; k < N; k++) begin
            if (oclr) m_ovr[k] = 0;
            if (set_k[k] != 0) m_ovr[k] = 1;
            if (dr[k]) begin
                m_hold[k] = int'(pc[k*CW +: CW]);
                m_pend[k] = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("strobe", 32'(strobe), 32'(m_strobe));
        check("valid", 32'(valid), 32'(m_valid));
        check("overrun", 32'(ovr), 32'(ovr_vec()));
        if (m_valid != 0) begin
            check("channel", 32'(chan), 32'(m_ch));
            check("count", 32'(cnt), 32'(m_cnt));
        end
`ifdef ENC_SCHED_SEQ_TAG_EN
        check("seq", 32'(seq), 32'(m_seq));
`endif
    endtask

    // Inputs are set at the falling edge; the model steps at the rising edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic quiet();
        rst = 1'b0; dr = '0; oclr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; dr = '0; oclr = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int nstrobe;
        int first;
        rst = 1'b1; en = 1'b1; dr = '0; pc = '0; rdy = 1'b1; oclr = 1'b0;
        step();
        rst = 1'b0;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_strobe", 32'(strobe), 32'd0);
        check("rst_channel", 32'(chan), 32'd0);
        check("rst_count", 32'(cnt), 32'd0);
        check("rst_overrun", 32'(ovr), 32'd0);

        // Window: one strobe every WC cycles, none while disabled, restart from 0.
        nstrobe = 0;
        for (int i = 0; i < 3 * WC; i++) begin
            step();
            nstrobe += int'(strobe);
        end
        check("strobe_count", 32'(nstrobe), 32'd3);
        for (int i = 0; i < 5; i++) step();
        en = 1'b0;
        nstrobe = 0;
        for (int i = 0; i < 2 * WC; i++) begin
            step();
            nstrobe += int'(strobe);
        end
        check("strobe_disabled", 32'(nstrobe), 32'd0);
        en = 1'b1;
        first = 0;
        for (int i = 1; i <= WC + 2; i++) begin
            step();
            if (strobe && first == 0) first = i;
        end
        check("strobe_restart", 32'(first), 32'(WC));

        // Single result on channel 2.
        do_reset();
        rdy = 1'b1;
        dr = 4'b0100; set_cnt(2, 16'h0123);
        step();
        dr = '0;
        check("single_t1_valid", 32'(valid), 32'd0);
        step();
        check("single_t2_valid", 32'(valid), 32'd1);
        check("single_ch", 32'(chan), 32'd2);
        check("single_cnt", 32'(cnt), 32'h0123);
        step();
        check("single_t3_valid", 32'(valid), 32'd0);

        // Fairness: all four at once, drained 0..3 with no gaps.
        do_reset();
        dr = 4'b1111;
        for (int k = 0; k < N; k++) set_cnt(k, 10 * (k + 1));
        step();
        dr = '0;
        for (int k = 0; k < N; k++) begin
            step();
            check("fair_valid", 32'(valid), 32'd1);
            check("fair_ch", 32'(chan), 32'(k));
            check("fair_cnt", 32'(cnt), 32'(10 * (k + 1)));
        end
        step();
        check("fair_drained", 32'(valid), 32'd0);

        // Backpressure with an overwrite on channel 1.
        do_reset();
        rdy = 1'b0;
        dr = 4'b0010; set_cnt(1, 3);
        step();
        dr = '0;
        step();
        dr = 4'b0010; set_cnt(1, 5);
        step();
        set_cnt(1, 7);
        step();
        dr = '0;
        step();
        check("bp_valid", 32'(valid), 32'd1);
        check("bp_cnt_stable", 32'(cnt), 32'd3);
        check("bp_overrun", 32'(ovr), 32'b0010);
        rdy = 1'b1;
        step();
        check("bp_next_cnt", 32'(cnt), 32'd7);
        check("bp_next_ch", 32'(chan), 32'd1);
        step();
        oclr = 1'b1;
        step();
        oclr = 1'b0;
        check("ovr_cleared", 32'(ovr), 32'd0);

        // Capture coinciding with grant on channel 0.
        do_reset();
        rdy = 1'b1;
        dr = 4'b0001; set_cnt(0, 16'h0AAA);
        step();
        set_cnt(0, 16'h0BBB);
        step();
        dr = '0;
        check("cg_old_cnt", 32'(cnt), 32'h0AAA);
        step();
        check("cg_new_valid", 32'(valid), 32'd1);
        check("cg_new_cnt", 32'(cnt), 32'h0BBB);
        check("cg_no_overrun", 32'(ovr), 32'd0);

        // Reset while presenting with three results pending.
        do_reset();
        rdy = 1'b0;
        dr = 4'b1111;
        step();
        dr = 4'b1110;
        step();
        dr = '0;
        check("pre_rst_valid", 32'(valid), 32'd1);
        do_reset();
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_overrun", 32'(ovr), 32'd0);
        rdy = 1'b1;
        step();
        step();
        check("mid_rst_no_pending", 32'(valid), 32'd0);
`ifdef ENC_SCHED_SEQ_TAG_EN
        check("seq_reset", 32'(seq), 32'd0);
        dr = 4'b0111;
        step();
        dr = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("seq_incr", 32'(seq), 32'(i));
        end
`endif

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 299) == 0);
            en   = ($urandom_range(0, 9) != 0);
            rdy  = ($urandom_range(0, 9) < 7);
            oclr = ($urandom_range(0, 29) == 0);
            for (int k = 0; k < N; k++) begin
                dr[k] = ($urandom_range(0, 5) == 0);
                set_cnt(k, int'($urandom_range(0, 65535)));
            end
            step();
        end
        quiet();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
